// File: rtl/lock_ctrl.sv
// Combination-lock controller: latches a user ID, collects a keypad code,
// compares it against that user's stored code, opens the lock and starts the
// door timer on a match, and escalates to an alarmed lockout after repeated
// failures. The stored code can be rewritten while the lock is open.
module lock_ctrl #(
    parameter int NUM_USERS = 4,
    parameter int DIGIT_W   = 4,
    parameter int CODE_LEN  = 4,
    parameter int MAX_TRIES = 3,
    localparam int UID_W    = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enter,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic [UID_W-1:0]   user_id,
    input  logic               prog,
    input  logic               timeout,
    output logic               timer_start,
    output logic               unlocked,
    output logic               alarm,
    output logic               err,
    output logic [2:0]         digit_cnt,
    output logic [2:0]         state_out
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam logic [2:0] LAST_CNT = 3'(CODE_LEN - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ENTRY   = 3'd1;
    localparam logic [2:0] CHECK   = 3'd2;
    localparam logic [2:0] OPEN    = 3'd3;
    localparam logic [2:0] PROGRAM = 3'd4;
    localparam logic [2:0] LOCKOUT = 3'd5;

    logic [2:0]        state_reg, state_next;
    logic [UID_W-1:0]  uid_reg, uid_next;
    logic [CODE_W-1:0] entry_reg, entry_next;
    logic [2:0]        digit_cnt_reg, digit_cnt_next;
    logic              unlocked_reg, unlocked_next;
    logic              alarm_reg, alarm_next;
    logic              err_reg, err_next;
    logic              timer_start_reg, timer_start_next;

    logic [CODE_W-1:0] code_reg [NUM_USERS];
    logic [FAIL_W-1:0] fail_reg [NUM_USERS];
    logic [CODE_W-1:0] code_default [NUM_USERS];

    logic              code_we;
    logic              fail_we;
    logic [FAIL_W-1:0] fail_wdata;
    logic [CODE_W-1:0] entry_shift;
    logic [CODE_W-1:0] cur_code;
    logic [FAIL_W-1:0] cur_fail;
    logic              last_digit;

    // Factory code for user u is u repeated in every digit position.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_USERS; gi++) begin : g_default
            assign code_default[gi] = {CODE_LEN{DIGIT_W'(gi)}};
        end
    endgenerate

    // New digit enters at the bottom, so the first digit ends up most significant.
    assign entry_shift = {entry_reg[CODE_W-DIGIT_W-1:0], digit_in};
    assign cur_code    = code_reg[uid_reg];
    assign cur_fail    = fail_reg[uid_reg];
    assign last_digit  = (digit_cnt_reg == LAST_CNT);

    // Next-state and next-output decode.
    always_comb begin
        state_next       = state_reg;
        uid_next         = uid_reg;
        entry_next       = entry_reg;
        digit_cnt_next   = digit_cnt_reg;
        err_next         = 1'b0;
        timer_start_next = 1'b0;
        code_we          = 1'b0;
        fail_we          = 1'b0;
        fail_wdata       = cur_fail;

        case (state_reg)
            IDLE: begin
                if (enter) begin
                    uid_next       = user_id;
                    entry_next     = '0;
                    digit_cnt_next = 3'd0;
                    state_next     = ENTRY;
                end
            end
            ENTRY: begin
                if (enter) begin
                    entry_next     = entry_shift;
                    digit_cnt_next = digit_cnt_reg + 3'd1;
                    if (last_digit) begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (entry_reg == cur_code) begin
                    state_next       = OPEN;
                    timer_start_next = 1'b1;
                    fail_we          = 1'b1;
                    fail_wdata       = '0;
                end else if ((int'(cur_fail) + 1) < MAX_TRIES) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                    fail_we    = 1'b1;
                    fail_wdata = cur_fail + 1'b1;
                end else begin
                    // The lockout reuses the door timer as its hold-off period.
                    state_next       = LOCKOUT;
                    timer_start_next = 1'b1;
                    fail_we          = 1'b1;
                    fail_wdata       = FAIL_W'(MAX_TRIES);
                end
            end
            OPEN: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (enter && prog) begin
                    state_next     = PROGRAM;
                    entry_next     = '0;
                    digit_cnt_next = 3'd0;
                end
            end
            PROGRAM: begin
                // Timeout has priority so a half-typed code is never committed.
                if (timeout) begin
                    state_next = IDLE;
                end else if (enter) begin
                    entry_next     = entry_shift;
                    digit_cnt_next = digit_cnt_reg + 3'd1;
                    if (last_digit) begin
                        code_we    = 1'b1;
                        state_next = OPEN;
                    end
                end
            end
            LOCKOUT: begin
                if (timeout) begin
                    state_next = IDLE;
                    fail_we    = 1'b1;
                    fail_wdata = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        unlocked_next = (state_next == OPEN) || (state_next == PROGRAM);
        alarm_next    = (state_next == LOCKOUT);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            uid_reg         <= '0;
            entry_reg       <= '0;
            digit_cnt_reg   <= 3'd0;
            unlocked_reg    <= 1'b0;
            alarm_reg       <= 1'b0;
            err_reg         <= 1'b0;
            timer_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            uid_reg         <= uid_next;
            entry_reg       <= entry_next;
            digit_cnt_reg   <= digit_cnt_next;
            unlocked_reg    <= unlocked_next;
            alarm_reg       <= alarm_next;
            err_reg         <= err_next;
            timer_start_reg <= timer_start_next;
        end
    end

    // Per-user stored codes and consecutive-failure counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                code_reg[i] <= code_default[i];
                fail_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_USERS; i++) begin
                if (code_we && (uid_reg == UID_W'(i))) begin
                    code_reg[i] <= entry_shift;
                end
                if (fail_we && (uid_reg == UID_W'(i))) begin
                    fail_reg[i] <= fail_wdata;
                end
            end
        end
    end

    assign timer_start = timer_start_reg;
    assign unlocked    = unlocked_reg;
    assign alarm       = alarm_reg;
    assign err         = err_reg;
    assign digit_cnt   = digit_cnt_reg;
    assign state_out   = state_reg;

endmodule

// File: tb/tb_lock_ctrl.sv
// Self-checking bench for lock_ctrl: a small behavioural model predicts the
// outcome of each code attempt, pushes it to a queue, and each scenario task
// pops and compares it once the result cycle has elapsed.
module tb_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enter;
    logic [3:0] digit_in;
    logic [1:0] user_id;
    logic       prog;
    logic       timeout;
    logic       timer_start;
    logic       unlocked;
    logic       alarm;
    logic       err;
    logic [2:0] digit_cnt;
    logic [2:0] state_out;

    int total = 0;
    int bad   = 0;

    // Expected {state, unlocked, alarm, err, timer_start} on the result cycle.
    logic [6:0]  sb [$];
    logic [15:0] model_code [4];
    int          model_fail [4];
    logic [6:0]  exp_v;

    lock_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .enter      (enter),
        .digit_in   (digit_in),
        .user_id    (user_id),
        .prog       (prog),
        .timeout    (timeout),
        .timer_start(timer_start),
        .unlocked   (unlocked),
        .alarm      (alarm),
        .err        (err),
        .digit_cnt  (digit_cnt),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [6:0] obs();
        return {state_out, unlocked, alarm, err, timer_start};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            model_code[i] = {4{4'(i)}};
            model_fail[i] = 0;
        end
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        enter    = 1'b1;
        digit_in = d;
        @(negedge clk);
        enter    = 1'b0;
    endtask

    // Full attempt: user-ID strobe then four digits. Pushes the predicted result.
    task automatic attempt(input logic [1:0] u, input logic [15:0] c);
        if (c == model_code[u]) begin
            model_fail[u] = 0;
            sb.push_back({3'd3, 1'b1, 1'b0, 1'b0, 1'b1});
        end else if (model_fail[u] + 1 < 3) begin
            model_fail[u] = model_fail[u] + 1;
            sb.push_back({3'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        end else begin
            model_fail[u] = 3;
            sb.push_back({3'd5, 1'b0, 1'b1, 1'b0, 1'b1});
        end
        @(negedge clk);
        enter    = 1'b1;
        user_id  = u;
        digit_in = 4'hF;
        @(negedge clk);
        enter    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            press(c[15-4*k -: 4]);
        end
    endtask

    task automatic pulse_timeout();
        @(negedge clk);
        timeout = 1'b1;
        @(negedge clk);
        timeout = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enter = 1'b0; digit_in = 4'd0; user_id = 2'd0;
        prog = 1'b0; timeout = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({obs(), digit_cnt} !== 10'd0) begin
            bad++;
            $display("FAIL reset_values: got %b want %b", {obs(), digit_cnt}, 10'd0);
        end
        rst = 1'b0;
        model_reset();
        $display("reset: outputs=%b digit_cnt=%0d", obs(), digit_cnt);
    endtask

    task automatic test_open_uid2();
        attempt(2'd2, 16'h2222);
        @(negedge clk);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) begin
            bad++;
            $display("FAIL open_uid2: got %b want %b", obs(), exp_v);
        end
        $display("open uid2: outputs=%b", obs());
        @(negedge clk);
        total++;
        if (obs() !== {3'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL open_ts_width: got %b want %b", obs(), {3'd3, 4'b1000});
        end
        pulse_timeout();
        total++;
        if (obs() !== 7'd0) begin
            bad++;
            $display("FAIL open_timeout: got %b want %b", obs(), 7'd0);
        end
        $display("timeout: outputs=%b", obs());
    endtask

    task automatic test_lockout_uid1();
        for (int n = 0; n < 3; n++) begin
            attempt(2'd1, 16'h1110);
            @(negedge clk);
            exp_v = sb.pop_front();
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL lockout_try%0d: got %b want %b", n, obs(), exp_v);
            end
            $display("wrong uid1 try %0d: outputs=%b", n, obs());
            @(negedge clk);
            total++;
            if (err !== 1'b0 || timer_start !== 1'b0) begin
                bad++;
                $display("FAIL lockout_pulse%0d: got err=%b ts=%b want 0 0", n, err, timer_start);
            end
        end
        @(negedge clk); enter = 1'b1; user_id = 2'd1;
        @(negedge clk); enter = 1'b0;
        for (int k = 0; k < 4; k++) press(4'd1);
        total++;
        if (obs() !== {3'd5, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL lockout_ignore_enter: got %b want %b", obs(), {3'd5, 4'b0100});
        end
        pulse_timeout();
        model_fail[1] = 0;
        total++;
        if (obs() !== 7'd0) begin
            bad++;
            $display("FAIL lockout_timeout: got %b want %b", obs(), 7'd0);
        end
        $display("lockout released: outputs=%b", obs());
    endtask

    task automatic test_fail_clear_uid0();
        logic [15:0] seq [5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0001};
        for (int n = 0; n < 5; n++) begin
            attempt(2'd0, seq[n]);
            @(negedge clk);
            exp_v = sb.pop_front();
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL fail_clear_%0d: got %b want %b", n, obs(), exp_v);
            end
            $display("uid0 code %h: outputs=%b", seq[n], obs());
            if (n == 2) pulse_timeout();
        end
    endtask

    task automatic test_program_uid3();
        logic [15:0] seq [2] = '{16'h3333, 16'h9876};
        attempt(2'd3, 16'h3333);
        @(negedge clk);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) begin
            bad++;
            $display("FAIL prog_open: got %b want %b", obs(), exp_v);
        end
        @(negedge clk); enter = 1'b1; prog = 1'b1;
        @(negedge clk); enter = 1'b0; prog = 1'b0;
        total++;
        if ({obs(), digit_cnt} !== {3'd4, 4'b1000, 3'd0}) begin
            bad++;
            $display("FAIL prog_enter: got %b want %b", {obs(), digit_cnt}, {3'd4, 4'b1000, 3'd0});
        end
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        model_code[3] = 16'h9876;
        total++;
        if (obs() !== {3'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL prog_done: got %b want %b", obs(), {3'd3, 4'b1000});
        end
        $display("program uid3 9876: outputs=%b", obs());
        pulse_timeout();
        for (int n = 0; n < 2; n++) begin
            attempt(2'd3, seq[n]);
            @(negedge clk);
            exp_v = sb.pop_front();
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL prog_verify_%0d: got %b want %b", n, obs(), exp_v);
            end
            $display("uid3 code %h: outputs=%b", seq[n], obs());
        end
        pulse_timeout();
    endtask

    task automatic test_program_abort();
        attempt(2'd0, 16'h0000);
        @(negedge clk);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) begin
            bad++;
            $display("FAIL abort_open: got %b want %b", obs(), exp_v);
        end
        @(negedge clk); enter = 1'b1; prog = 1'b1;
        @(negedge clk); enter = 1'b0; prog = 1'b0;
        press(4'd5); press(4'd5);
        @(negedge clk); enter = 1'b1; timeout = 1'b1; digit_in = 4'd5;
        @(negedge clk); enter = 1'b0; timeout = 1'b0;
        total++;
        if (obs() !== 7'd0) begin
            bad++;
            $display("FAIL abort_timeout: got %b want %b", obs(), 7'd0);
        end
        attempt(2'd0, 16'h0000);
        @(negedge clk);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) begin
            bad++;
            $display("FAIL abort_old_code: got %b want %b", obs(), exp_v);
        end
        $display("program abort, old code: outputs=%b", obs());
        pulse_timeout();
    endtask

    task automatic test_reset_mid();
        logic [1:0]  us [4] = '{2'd1, 2'd2, 2'd2, 2'd3};
        logic [15:0] cs [4] = '{16'h1111, 16'h2220, 16'h2222, 16'h3333};
        // Mid-entry with three digits typed.
        @(negedge clk); enter = 1'b1; user_id = 2'd1;
        @(negedge clk); enter = 1'b0;
        press(4'd1); press(4'd1); press(4'd1);
        total++;
        if ({state_out, digit_cnt} !== {3'd1, 3'd3}) begin
            bad++;
            $display("FAIL mid_entry: got %b want %b", {state_out, digit_cnt}, {3'd1, 3'd3});
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({obs(), digit_cnt} !== 10'd0) begin
            bad++;
            $display("FAIL reset_mid_entry: got %b want %b", {obs(), digit_cnt}, 10'd0);
        end
        @(negedge clk); rst = 1'b0;
        model_reset();
        // Drive uid2 into lockout.
        for (int n = 0; n < 3; n++) begin
            attempt(2'd2, 16'h2220);
            @(negedge clk);
            exp_v = sb.pop_front();
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL pre_lock_%0d: got %b want %b", n, obs(), exp_v);
            end
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({obs(), digit_cnt} !== 10'd0) begin
            bad++;
            $display("FAIL reset_lockout: got %b want %b", {obs(), digit_cnt}, 10'd0);
        end
        @(negedge clk); rst = 1'b0;
        model_reset();
        $display("reset during lockout: outputs=%b", obs());
        // Defaults restored, uid2 fail count cleared, uid3 code restored.
        for (int n = 0; n < 4; n++) begin
            attempt(us[n], cs[n]);
            @(negedge clk);
            exp_v = sb.pop_front();
            total++;
            if (obs() !== exp_v) begin
                bad++;
                $display("FAIL post_reset_%0d: got %b want %b", n, obs(), exp_v);
            end
            $display("post-reset uid%0d code %h: outputs=%b", us[n], cs[n], obs());
            if (obs() === {3'd3, 4'b1001}) pulse_timeout();
        end
    endtask

    initial begin
        test_reset();
        test_open_uid2();
        test_lockout_uid1();
        test_fail_clear_uid0();
        test_program_uid3();
        test_program_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
